spi_tx_slot_sched: RTL

Byte-slot scheduler for the SPI slave transmit path. It runs in the SCK-derived trigger-clock domain, one edge per SPI bit while chip-select is active. It skips a fixed header of bit periods, then divides the transaction into 8-bit slots and grants each slot to one of NREQ byte sources by round-robin arbitration. Its grant, bit-index and window outputs drive the 8-bit transmit PHY's data selection and yield timing; the whole block is cleared between transactions by the chip-select-derived reset.

---
 rtl/spi_tx_slot_sched_if.sv | 24 ++
 rtl/spi_tx_slot_sched.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/spi_tx_slot_sched_if.sv
// Slot-scheduler bundle: requests in, slot grant and bit/byte timing out.
// The master side is the requester/PHY side; the scheduler uses the slave side.
interface spi_tx_slot_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] grant;
  logic            byte_start;
  logic [2:0]      bit_idx;
  logic [7:0]      byte_idx;
  logic            tx_window;
  logic            idle_slot;
  logic            frame_done;

  modport master (
    output req,
    input  grant, byte_start, bit_idx, byte_idx, tx_window, idle_slot, frame_done
  );

  modport slave (
    input  req,
    output grant, byte_start, bit_idx, byte_idx, tx_window, idle_slot, frame_done
  );
endinterface

// File: rtl/spi_tx_slot_sched.sv
// SPI TX byte-slot scheduler: header skip, then 8-bit slots granted round-robin (registered outputs).
// Define SPI_TXSCHED_FIXED_PRI_EN for lowest-index-wins fixed priority instead of round-robin.
module spi_tx_slot_sched #(
  parameter int NREQ      = 4,
  parameter int HDR_BITS  = 8,
  parameter int MAX_BYTES = 16
) (
  input  logic               trigger_clock,
  input  logic               trigger_rst_n,
  spi_tx_slot_sched_if.slave bus
);
  localparam int PTR_W = $clog2(NREQ);

  typedef enum logic [1:0] {HDR, SLOT, DONE} state_t;

  state_t          state_q, state_nxt;
  logic [7:0]      hdr_cnt_q, hdr_cnt_nxt;
  logic [2:0]      bit_idx_q, bit_idx_nxt;
  logic [7:0]      byte_idx_q, byte_idx_nxt;
  logic [NREQ-1:0] grant_q, grant_nxt;
  logic            idle_q, idle_nxt;
  logic            byte_start_q, byte_start_nxt;
  logic            tx_window_q, tx_window_nxt;
  logic            frame_done_q, frame_done_nxt;
  logic [NREQ-1:0] req_s1, req_s2;
  logic [7:0]      byte_idx_inc;

  logic [NREQ-1:0] arb_grant;
  logic            arb_found;
  logic [PTR_W-1:0] arb_idx;

`ifndef SPI_TXSCHED_FIXED_PRI_EN
  logic [PTR_W-1:0] ptr_q, ptr_nxt;
  int               cand;
`endif

  // Arbitration sees only the second synchronizer stage.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_grant = '0;
`ifdef SPI_TXSCHED_FIXED_PRI_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_s2[i]) begin
        arb_found = 1'b1;
        arb_idx   = PTR_W'(i);
      end
    end
`else
    cand = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!arb_found && req_s2[cand]) begin
        arb_found = 1'b1;
        arb_idx   = PTR_W'(cand);
      end
    end
`endif
    if (arb_found) arb_grant[arb_idx] = 1'b1;
  end

  assign byte_idx_inc = byte_idx_q + 8'd1;

  always_comb begin
    state_nxt      = state_q;
    hdr_cnt_nxt    = hdr_cnt_q;
    bit_idx_nxt    = bit_idx_q;
    byte_idx_nxt   = byte_idx_q;
    grant_nxt      = grant_q;
    idle_nxt       = idle_q;
    byte_start_nxt = byte_start_q;
    tx_window_nxt  = tx_window_q;
    frame_done_nxt = frame_done_q;
`ifndef SPI_TXSCHED_FIXED_PRI_EN
    ptr_nxt        = ptr_q;
`endif
    unique case (state_q)
      HDR: begin
        hdr_cnt_nxt = hdr_cnt_q + 8'd1;
        if (hdr_cnt_q == 8'(HDR_BITS - 1)) begin
          state_nxt      = SLOT;
          byte_start_nxt = 1'b1;
          bit_idx_nxt    = 3'd0;
          tx_window_nxt  = 1'b1;
          grant_nxt      = arb_grant;
          idle_nxt       = !arb_found;
`ifndef SPI_TXSCHED_FIXED_PRI_EN
          if (arb_found) ptr_nxt = arb_idx;
`endif
        end
      end
      SLOT: begin
        bit_idx_nxt    = bit_idx_q + 3'd1;
        byte_start_nxt = 1'b0;
        if (bit_idx_q == 3'd7) begin
          byte_idx_nxt = byte_idx_inc;
          if (byte_idx_inc == 8'(MAX_BYTES)) begin
            state_nxt      = DONE;
            bit_idx_nxt    = 3'd7;
            grant_nxt      = '0;
            idle_nxt       = 1'b0;
            tx_window_nxt  = 1'b0;
            frame_done_nxt = 1'b1;
          end else begin
            byte_start_nxt = 1'b1;
            bit_idx_nxt    = 3'd0;
            grant_nxt      = arb_grant;
            idle_nxt       = !arb_found;
`ifndef SPI_TXSCHED_FIXED_PRI_EN
            if (arb_found) ptr_nxt = arb_idx;
`endif
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge trigger_clock or negedge trigger_rst_n) begin
    if (!trigger_rst_n) begin
      state_q      <= HDR;
      hdr_cnt_q    <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      grant_q      <= '0;
      idle_q       <= 1'b0;
      byte_start_q <= 1'b0;
      tx_window_q  <= 1'b0;
      frame_done_q <= 1'b0;
      req_s1       <= '0;
      req_s2       <= '0;
`ifndef SPI_TXSCHED_FIXED_PRI_EN
      ptr_q        <= PTR_W'(NREQ - 1);
`endif
    end else begin
      state_q      <= state_nxt;
      hdr_cnt_q    <= hdr_cnt_nxt;
      bit_idx_q    <= bit_idx_nxt;
      byte_idx_q   <= byte_idx_nxt;
      grant_q      <= grant_nxt;
      idle_q       <= idle_nxt;
      byte_start_q <= byte_start_nxt;
      tx_window_q  <= tx_window_nxt;
      frame_done_q <= frame_done_nxt;
      req_s1       <= bus.req;
      req_s2       <= req_s1;
`ifndef SPI_TXSCHED_FIXED_PRI_EN
      ptr_q        <= ptr_nxt;
`endif
    end
  end

  assign bus.grant      = grant_q;
  assign bus.byte_start = byte_start_q;
  assign bus.bit_idx    = bit_idx_q;
  assign bus.byte_idx   = byte_idx_q;
  assign bus.tx_window  = tx_window_q;
  assign bus.idle_slot  = idle_q;
  assign bus.frame_done = frame_done_q;
endmodule
